// File: rtl/led_pattern_seq_pkg.sv
// led_seq_pkg: mode encodings, pattern load constants and PWM width for the LED sequencer.
package led_seq_pkg;
    localparam int PWM_BITS = 4;
    typedef logic [1:0] mode_t;
    localparam mode_t MODE_BLINK  = 2'd0;
    localparam mode_t MODE_RUN    = 2'd1;
    localparam mode_t MODE_BOUNCE = 2'd2;
    localparam mode_t MODE_OFF    = 2'd3;
    localparam logic [7:0] PAT_BLINK_INIT = 8'h00;
    localparam logic [7:0] PAT_SHIFT_INIT = 8'h01;
    function automatic logic [7:0] load_pattern(input mode_t m);
        return (m == MODE_RUN || m == MODE_BOUNCE) ? PAT_SHIFT_INIT : PAT_BLINK_INIT;
    endfunction
endpackage

// File: rtl/led_pattern_seq_if.sv
// led_pattern_seq_if: button/brightness inputs and LED/mode/step outputs of the sequencer.
interface led_pattern_seq_if;
    import led_seq_pkg::*;
    logic                BTN;
    logic [PWM_BITS-1:0] BRIGHT;
    logic [7:0]          LED;
    mode_t               MODE;
    logic                STEP;
    modport master(output BTN, BRIGHT, input LED, MODE, STEP);
    modport slave(input BTN, BRIGHT, output LED, MODE, STEP);
endinterface

// File: rtl/led_pattern_seq_btn_debounce.sv
// btn_debounce: synchronizes the raw button and emits a pulse as the debounced level rises.
module btn_debounce #(
    parameter int DB_CYCLES = 5
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DB_CYCLES);
    logic [1:0]    sync;
    logic [CW-1:0] cnt;
    logic          done;
    // rise fires in the cycle where level is about to go high
    assign done = (sync[1] != level) && (cnt == CW'(DB_CYCLES - 1));
    assign rise = done && sync[1];
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync  <= '0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            sync <= {sync[0], BTN};
            cnt  <= (sync[1] == level || done) ? '0 : cnt + 1'b1;
            if (done) level <= sync[1];
        end
    end
endmodule

// File: rtl/led_pattern_seq.sv
// led_pattern_seq: button-selected animated LED patterns with PWM brightness.
module led_pattern_seq
    import led_seq_pkg::*;
#(
    parameter int CLK_HZ      = 12000000,
    parameter int STEP_HZ     = 8,
    parameter int DEBOUNCE_MS = 20
) (
    input logic CLK,
    input logic RST,
    led_pattern_seq_if.slave io
);
    localparam int STEP_DIV  = CLK_HZ / STEP_HZ;
    localparam int DB_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int PW        = $clog2(STEP_DIV);
    logic [PW-1:0]       presc;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [7:0]          pattern, pat_step;
    logic                dir_right, dir_next, step_tick, adv, en;
    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
        .CLK(CLK), .RST(RST), .BTN(io.BTN), .level(), .rise(adv)
    );
    assign step_tick = presc == PW'(STEP_DIV - 1);
    assign en        = (&io.BRIGHT) | (pwm_cnt < io.BRIGHT);
    // bounce turns around at either end instead of shifting off the edge
    always_comb begin
        dir_next = dir_right;
        pat_step = pattern;
        case (io.MODE)
            MODE_BLINK: pat_step = ~pattern;
            MODE_RUN:   pat_step = {pattern[6:0], pattern[7]};
            MODE_BOUNCE: begin
                dir_next = dir_right ? pattern != 8'h01 : pattern == 8'h80;
                pat_step = dir_next ? pattern >> 1 : pattern << 1;
            end
            default: pat_step = 8'h00;
        endcase
    end
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            presc     <= '0;
            pwm_cnt   <= '0;
            pattern   <= 8'h00;
            dir_right <= 1'b0;
            io.MODE   <= MODE_BLINK;
            io.LED    <= 8'h00;
            io.STEP   <= 1'b0;
        end else begin
            presc   <= (adv || step_tick) ? '0 : presc + 1'b1;
            pwm_cnt <= pwm_cnt + 1'b1;
            io.STEP <= step_tick && !adv;
            io.LED  <= pattern & {8{en}};
            if (adv) begin
                io.MODE   <= mode_t'(io.MODE + 1'b1);
                pattern   <= load_pattern(mode_t'(io.MODE + 1'b1));
                dir_right <= 1'b0;
            end else if (step_tick) begin
                pattern   <= pat_step;
                dir_right <= dir_next;
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_seq.sv
// tb_led_pattern_seq: directed/random stimulus checked against a cycle model of the sequencer.
module tb_led_pattern_seq;
    import led_seq_pkg::*;
    localparam int DIV = 10;
    localparam int DB  = 5;
    logic clk = 1'b0;
    logic rst = 1'b1;
    led_pattern_seq_if io();
    led_pattern_seq #(.CLK_HZ(1000), .STEP_HZ(100), .DEBOUNCE_MS(5)) dut (
        .CLK(clk), .RST(rst), .io(io)
    );
    always #5 clk = ~clk;
    int tests = 0;
    int fails = 0;
    int m_mode, k, phase, pwm, run;
    bit s1, s2, stable_m, m_step;
    logic [7:0] m_led;

    // pattern as a function of mode and steps taken since the last load
    function automatic logic [7:0] pat_of(input int md, input int kk);
        int p;
        p = kk % 14;
        case (md)
            0: return (kk % 2) ? 8'hFF : 8'h00;
            1: return 8'(1 << (kk % 8));
            2: return 8'(1 << ((p <= 7) ? p : 14 - p));
            default: return 8'h00;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; k = 0; phase = 0; pwm = 0; run = 0;
        s1 = 0; s2 = 0; stable_m = 0; m_step = 0; m_led = 8'h00;
    endtask

    task automatic model_edge();
        bit tick, adv, flip, en;
        flip   = (s2 != stable_m) && (run + 1 == DB);
        adv    = flip && s2;
        tick   = phase == DIV - 1;
        en     = (io.BRIGHT == 15) || (pwm < int'(io.BRIGHT));
        m_led  = en ? pat_of(m_mode, k) : 8'h00;
        m_step = tick && !adv;
        if (adv) begin
            m_mode = (m_mode + 1) % 4; k = 0; phase = 0;
        end else if (tick) begin
            k++; phase = 0;
        end else phase++;
        pwm = (pwm + 1) % 16;
        if (s2 == stable_m) run = 0;
        else if (flip) begin stable_m = s2; run = 0; end
        else run++;
        s2 = s1;
        s1 = io.BTN;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        chk("led", io.LED, m_led);
        chk("mode", io.MODE, m_mode);
        chk("step", io.STEP, m_step);
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic press(input int hold);
        io.BTN = 1'b1;
        cycles(hold);
        io.BTN = 1'b0;
        cycles(hold);
    endtask

    task automatic wait_mode(input int target, output int n);
        n = 0;
        while (io.MODE !== 2'(target) && n < 30) begin
            cycle();
            n++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n, cnt, g;
        io.BTN = 1'b0;
        io.BRIGHT = 4'd15;
        model_reset();
        #1;
        chk("reset_led", io.LED, 8'h00);
        chk("reset_mode", io.MODE, 0);
        chk("reset_step", io.STEP, 0);
        cycles(2);
        rst = 1'b0;
        // blink with full brightness
        cnt = 0;
        repeat (40) begin cycle(); cnt += int'(io.STEP); end
        chk("t1_step_count", cnt, 4);
        chk("t1_led_on", io.LED, 8'hFF);
        // short glitch, then a held press
        g = $urandom_range(1, 3);
        io.BTN = 1'b1;
        cycles(g);
        io.BTN = 1'b0;
        cycles(12);
        chk("t2_glitch_mode", io.MODE, 0);
        io.BTN = 1'b1;
        wait_mode(1, n);
        chk("t2_adv_latency", n, 7);
        cycles(20 - n);
        io.BTN = 1'b0;
        cycles(15);
        chk("t2_single_adv", io.MODE, 1);
        cycles(90);
        // bounce
        press(10);
        chk("t3_mode", io.MODE, 2);
        repeat (160) begin cycle(); chk("t3_onehot", $onehot(io.LED), 1); end
        press(10);
        cycles(10);
        chk("off_led", io.LED, 8'h00);
        press(10);
        press(10);
        chk("t4_mode_run", io.MODE, 1);
        // brightness
        io.BRIGHT = 4'd4;
        cnt = 0;
        repeat (160) begin cycle(); cnt += int'(io.LED != 8'h00); end
        chk("t4_duty4", cnt, 40);
        io.BRIGHT = 4'd0;
        cnt = 0;
        repeat (160) begin cycle(); cnt += int'(io.LED != 8'h00); end
        chk("t4_duty0", cnt, 0);
        io.BRIGHT = 4'd15;
        cnt = 0;
        repeat (160) begin cycle(); cnt += int'(io.LED != 8'h00); end
        chk("t4_duty15", cnt, 160);
        repeat (3) begin
            io.BRIGHT = 4'($urandom_range(0, 15));
            cycles(48);
        end
        io.BRIGHT = 4'd15;
        // advance lands on a step tick
        n = 0;
        while (phase != 3 && n < 20) begin cycle(); n++; end
        io.BTN = 1'b1;
        wait_mode(2, n);
        chk("t5_adv_latency", n, 7);
        cycle();
        chk("t5_load", io.LED, 8'h01);
        n = 1;
        while (io.STEP !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("t5_next_step", n, 10);
        io.BTN = 1'b0;
        cycles(10);
        // reset mid-bounce with the button held
        cycles(23);
        io.BTN = 1'b1;
        cycles(3);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        chk("t6_rst_led", io.LED, 8'h00);
        chk("t6_rst_mode", io.MODE, 0);
        chk("t6_rst_step", io.STEP, 0);
        cycles(3);
        rst = 1'b0;
        wait_mode(1, n);
        chk("t6_adv_latency", n, 7);
        cycles(20);
        chk("t6_single_adv", io.MODE, 1);
        io.BTN = 1'b0;
        cycles(10);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
